// File: rtl/ds_dac_pkg.sv
// Shared types, widths and arithmetic helpers for the multi-channel
// delta-sigma DAC.
package ds_dac_pkg;

    // Modulator order, as selected by order_sel.
    typedef enum logic {
        ORD_FIRST  = 1'b0,
        ORD_SECOND = 1'b1
    } order_e;

    // Extra bits above the sample width for each modulator's state.
    // First order: the accumulator needs one carry bit (W+1).
    // Second order: the integrators need headroom for loop transients (W+4).
    localparam int ACC1_EXTRA = 1;
    localparam int ACC2_EXTRA = 4;

    // Midscale code for a w-bit unsigned sample: 2^(w-1).
    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    // a + b clamped to the signed range of a bits-wide word.
    function automatic longint sat_add(input longint a, input longint b, input int bits);
        longint s;
        longint hi;
        longint lo;
        s  = a + b;
        hi = (longint'(1) << (bits - 1)) - 1;
        lo = -(longint'(1) << (bits - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/ds_dac_multi_core.sv
// One delta-sigma channel: sample format/mute, first- and second-order
// modulators, and the state clear that follows an order change.
// All state moves only on tick.
module ds_mod_core
    import ds_dac_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clear,
    input  logic         order,
    input  logic [W-1:0] sample,
    input  logic         signed_fmt,
    input  logic         mute,
    output logic         out
);

    localparam int           A1W = W + ACC1_EXTRA;
    localparam int           A2W = W + ACC2_EXTRA;
    localparam logic [W-1:0] MID = W'(midscale(W));

    logic [A1W-1:0]        acc_q, acc_d;
    logic signed [A2W-1:0] i1_q, i1_d;
    logic signed [A2W-1:0] i2_q, i2_d;
    logic                  out_q, out_d;

    logic [W-1:0]          x;
    logic [A1W-1:0]        acc_base;
    logic [A1W-1:0]        s1;
    logic signed [A2W-1:0] i1_base, i2_base;
    logic                  out_base;
    longint                u, f, i1_next, i2_next;

    // Map the active sample to unsigned offset binary; mute forces midscale.
    always_comb begin
        x = sample;
        if (signed_fmt) begin
            x = {~sample[W-1], sample[W-2:0]};
        end
        if (mute) begin
            x = MID;
        end
    end

    // Next modulator state. On a clearing tick the loop starts from reset
    // values and still modulates on that same tick.
    always_comb begin
        acc_base = clear ? A1W'(midscale(W)) : acc_q;
        i1_base  = clear ? '0 : i1_q;
        i2_base  = clear ? '0 : i2_q;
        out_base = clear ? 1'b0 : out_q;

        s1 = acc_base + {1'b0, x};

        u       = longint'(x) - longint'(midscale(W));
        f       = out_base ? longint'(midscale(W)) : -longint'(midscale(W));
        i1_next = sat_add(longint'(i1_base), u - f, A2W);
        i2_next = sat_add(longint'(i2_base), i1_next - f, A2W);

        acc_d = acc_q;
        i1_d  = i1_q;
        i2_d  = i2_q;
        out_d = out_q;
        if (tick) begin
            acc_d = acc_base;
            i1_d  = i1_base;
            i2_d  = i2_base;
            if (order_e'(order) == ORD_SECOND) begin
                i1_d  = A2W'(i1_next);
                i2_d  = A2W'(i2_next);
                out_d = (i2_next >= 0);
            end else begin
                // s >= 2^W shows up as the carry bit; subtracting 2^W drops it.
                out_d = s1[W];
                acc_d = {1'b0, s1[W-1:0]};
            end
        end
    end

    // Modulator state and the registered pulse output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= A1W'(midscale(W));
            i1_q  <= '0;
            i2_q  <= '0;
            out_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/ds_dac_multi.sv
// Multi-channel delta-sigma DAC top: modulator tick divider, one-frame
// valid/ready buffer, active sample register, order-change tracking and
// one ds_mod_core per channel.
module ds_dac_multi
    import ds_dac_pkg::*;
#(
    parameter int W   = 8,
    parameter int CH  = 2,
    parameter int DIV = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH*W-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          order_sel,
    input  logic          signed_fmt,
    input  logic          mute,
    output logic [CH-1:0] out,
    output logic          underrun
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DIV - 1);
    localparam logic [W-1:0]  MID    = W'(midscale(W));

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CH*W-1:0] buf_q, buf_d;
    logic            full_q, full_d;
    logic [CH*W-1:0] active_q, active_d;
    logic            underrun_q, underrun_d;
    order_e          order_q, order_d;
    logic            clr_q, clr_d;

    logic            tick;
    logic            accept;

    assign tick     = (cnt_q == CNT_TC);
    assign in_ready = ~full_q | tick;
    assign accept   = in_valid & in_ready;

    // Next-state for divider, frame buffer, active sample and order tracking.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        // A tick drains the buffer; an accept on the same cycle refills it.
        buf_d  = accept ? in_data : buf_q;
        full_d = accept ? 1'b1 : (tick ? 1'b0 : full_q);

        active_d   = (tick & full_q) ? buf_q : active_q;
        underrun_d = tick & ~full_q;

        // A change of order arms a clear that the next tick consumes. A change
        // seen on a tick cycle re-arms so the following tick still clears.
        order_d = order_e'(order_sel);
        if (order_sel != logic'(order_q)) begin
            clr_d = 1'b1;
        end else if (tick) begin
            clr_d = 1'b0;
        end else begin
            clr_d = clr_q;
        end
    end

    // Control and sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            buf_q      <= '0;
            full_q     <= 1'b0;
            active_q   <= {CH{MID}};
            underrun_q <= 1'b0;
            order_q    <= ORD_FIRST;
            clr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            active_q   <= active_d;
            underrun_q <= underrun_d;
            order_q    <= order_d;
            clr_q      <= clr_d;
        end
    end

    assign underrun = underrun_q;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        ds_mod_core #(
            .W(W)
        ) u_core (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .clear      (clr_q),
            .order      (logic'(order_q)),
            .sample     (active_q[k*W +: W]),
            .signed_fmt (signed_fmt),
            .mute       (mute),
            .out        (out[k])
        );
    end

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi: one instance with DIV=1 for density,
// mute, order-change and latency checks, one with DIV=4 for handshake and
// underrun checks. Expected results go through a queue.
module tb_ds_dac_multi;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CH*W-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_valid_b = 1'b0;
    logic            order_sel = 1'b0;
    logic            signed_fmt = 1'b0;
    logic            mute = 1'b0;

    logic            in_ready_a, in_ready_b;
    logic            underrun_a, underrun_b;
    logic [CH-1:0]   out_a, out_b;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ds_dac_multi #(.W(W), .CH(CH), .DIV(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .order_sel  (order_sel),
        .signed_fmt (signed_fmt),
        .mute       (mute),
        .out        (out_a),
        .underrun   (underrun_a)
    );

    ds_dac_multi #(.W(W), .CH(CH), .DIV(4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .order_sel  (order_sel),
        .signed_fmt (signed_fmt),
        .mute       (mute),
        .out        (out_b),
        .underrun   (underrun_b)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // Ones on each dut_a channel over 256 consecutive ticks (DIV=1).
    task automatic measure_a(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(out_a[0]);
            c1 += int'(out_a[1]);
        end
    endtask

    task automatic density(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input int e0, input int e1, input int tol, input int settle);
        int c0, c1, x0, x1;
        @(negedge clk);
        in_data  = {d1, d0};
        in_valid = 1'b1;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        repeat (settle) @(negedge clk);
        measure_a(c0, c1);
        x0 = exp_q.pop_front();
        x1 = exp_q.pop_front();
        chk({tag, "_ch0"}, c0, x0, tol);
        chk({tag, "_ch1"}, c1, x1, tol);
    endtask

    initial begin
        int cnt_m, full_m, und_m, tick_m, rdy_m, acc_m;
        int n_acc, n_und, c0, c1, saw_low;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_a", int'(out_a), 0, 0);
        chk("rst_out_b", int'(out_b), 0, 0);
        chk("rst_ready_a", int'(in_ready_a), 1, 0);
        chk("rst_ready_b", int'(in_ready_b), 1, 0);
        chk("rst_underrun_a", int'(underrun_a), 0, 0);
        reset = 1'b0;

        // First order, unsigned densities
        density("t1_w1", 8'h40, 8'hC0, 64, 192, 0, 4);
        density("t1_w2", 8'h40, 8'hC0, 64, 192, 0, 0);
        density("t2_a", 8'h00, 8'hFF, 0, 255, 0, 4);
        density("t2_b", 8'hFF, 8'h00, 255, 0, 0, 4);

        // Signed format and mute
        signed_fmt = 1'b1;
        density("t3_signed0", 8'h00, 8'h00, 128, 128, 0, 4);
        mute = 1'b1;
        density("t3_mute7f", 8'h7F, 8'h7F, 128, 128, 0, 4);

        // Mute timing from a known accumulator (reset -> acc = 128, data 0)
        @(negedge clk);
        reset      = 1'b1;
        mute       = 1'b0;
        signed_fmt = 1'b0;
        in_data    = '0;
        in_valid   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_premute", int'(out_a), 0, 0);
        mute = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        repeat (3) begin
            @(negedge clk);
            chk("t3_mute_tick", int'(out_a), exp_q.pop_front(), 0);
        end
        mute = 1'b0;
        @(negedge clk);
        chk("t3_unmute_tick", int'(out_a), 0, 0);

        // Second order
        order_sel = 1'b1;
        density("t5_o2_80", 8'h80, 8'h80, 128, 128, 2, 600);
        @(negedge clk);
        in_data = {8'h40, 8'h40};
        repeat (10) @(negedge clk);
        // Switch to first order: one tick with old state, then a clean restart
        order_sel = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("t5_clr_to_o1", int'(out_a), exp_q.pop_front(), 0);
        end
        // Back to second order: integrators restart from zero
        order_sel = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("t5_clr_to_o2", int'(out_a), exp_q.pop_front(), 0);
        end
        density("t5_o2_40", 8'h40, 8'h40, 64, 64, 2, 600);

        // DIV=4 handshake and underrun
        @(negedge clk);
        reset      = 1'b1;
        order_sel  = 1'b0;
        in_valid   = 1'b0;
        in_data    = {8'hC0, 8'h40};
        in_valid_b = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        cnt_m  = 0;
        full_m = 0;
        und_m  = 0;
        n_acc  = 0;
        n_und  = 0;
        exp_q.push_back(11);
        exp_q.push_back(9);
        for (int i = 0; i < 84; i++) begin
            if (i == 40) in_valid_b = 1'b0;
            #1;
            tick_m = (cnt_m == 3) ? 1 : 0;
            rdy_m  = (full_m == 0 || tick_m == 1) ? 1 : 0;
            chk("t4_ready", int'(in_ready_b), rdy_m, 0);
            chk("t4_underrun", int'(underrun_b), und_m, 0);
            if (i < 40 && in_valid_b && in_ready_b) n_acc++;
            if (i >= 40 && underrun_b) n_und++;
            acc_m  = (in_valid_b && rdy_m == 1) ? 1 : 0;
            und_m  = (tick_m == 1 && full_m == 0) ? 1 : 0;
            full_m = (acc_m == 1) ? 1 : ((tick_m == 1) ? 0 : full_m);
            cnt_m  = (tick_m == 1) ? 0 : cnt_m + 1;
            @(negedge clk);
        end
        chk("t4_accepts", n_acc, exp_q.pop_front(), 0);
        chk("t4_underrun_pulses", n_und, exp_q.pop_front(), 0);

        // Starved DIV=4 channel keeps the last frame's density
        exp_q.push_back(64);
        exp_q.push_back(192);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 256; i++) begin
            repeat (4) @(negedge clk);
            c0 += int'(out_b[0]);
            c1 += int'(out_b[1]);
        end
        chk("t4_hold_ch0", c0, exp_q.pop_front(), 0);
        chk("t4_hold_ch1", c1, exp_q.pop_front(), 0);

        // Reset mid-stream with the DIV=4 buffer full
        in_valid_b = 1'b1;
        in_valid   = 1'b1;
        saw_low    = 0;
        repeat (5) begin
            @(negedge clk);
            if (!in_ready_b) saw_low = 1;
        end
        chk("t6_prefull", saw_low, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_out_a", int'(out_a), 0, 0);
        chk("t6_rst_out_b", int'(out_b), 0, 0);
        chk("t6_rst_ready_b", int'(in_ready_b), 1, 0);
        chk("t6_rst_ready_a", int'(in_ready_a), 1, 0);
        chk("t6_rst_underrun_a", int'(underrun_a), 0, 0);
        chk("t6_rst_underrun_b", int'(underrun_b), 0, 0);

        // Post-reset latency on dut_a: frame 0x00 accepted on the second tick
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        in_data    = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // pairs of (out, underrun) after ticks p0..p4
        exp_q.push_back(3); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(3); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_lat_out", int'(out_a), exp_q.pop_front(), 0);
            chk("t6_lat_underrun", int'(underrun_a), exp_q.pop_front(), 0);
            in_valid = (i == 0) ? 1'b1 : 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
